// File: rtl/i2s_audio_tx.sv
// I2S serialiser: 16-bit stereo PCM into a fixed 64-BCK frame with a one-cycle frame strobe.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified output instead of standard I2S.
module i2s_audio_tx #(
    parameter int BCK_HALF    = 8,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [SAMPLE_BITS-1:0] AUDIO_L,
    input  logic [SAMPLE_BITS-1:0] AUDIO_R,
    input  logic                   SAMPLE_STB,
    output logic                   FRAME_STB,
    output logic                   I2S_BCK,
    output logic                   I2S_LRCK,
    output logic                   I2S_DATA
);

    localparam int DIV_W = (BCK_HALF > 2) ? $clog2(BCK_HALF) : 1;

    // Channel word is placed in a 32-slot vector whose MSB is slot p=0.
`ifdef I2S_LEFT_JUSTIFIED_EN
    localparam int SLOT_SHIFT = 32 - SAMPLE_BITS;
`else
    localparam int SLOT_SHIFT = 31 - SAMPLE_BITS;
`endif

    logic [DIV_W-1:0]       div;
    logic [5:0]             b;
    logic [SAMPLE_BITS-1:0] hold_l, hold_r;
    logic [SAMPLE_BITS-1:0] sh_l, sh_r;

    logic                   div_wrap;
    logic                   bck_fall;
    logic                   frame_load;
    logic [5:0]             b_next;
    logic [4:0]             p_next;
    logic [SAMPLE_BITS-1:0] in_l, in_r;
    logic [SAMPLE_BITS-1:0] word_l_next, word_r_next;
    logic [SAMPLE_BITS-1:0] slot_word;
    logic [31:0]            slot_vec;
    logic                   data_next;
    logic                   lrck_next;

    always_comb begin
        div_wrap    = (div == DIV_W'(BCK_HALF - 1));
        bck_fall    = div_wrap && I2S_BCK;
        b_next      = b + 6'd1;
        p_next      = b_next[4:0];
        frame_load  = bck_fall && (b == 6'd63);
        in_l        = SAMPLE_STB ? AUDIO_L : hold_l;
        in_r        = SAMPLE_STB ? AUDIO_R : hold_r;
        word_l_next = frame_load ? in_l : sh_l;
        word_r_next = frame_load ? in_r : sh_r;
        slot_word   = b_next[5] ? word_r_next : word_l_next;
        slot_vec    = 32'(slot_word) << SLOT_SHIFT;
        data_next   = slot_vec[5'd31 - p_next];
`ifdef I2S_LEFT_JUSTIFIED_EN
        lrck_next   = ~b_next[5];
`else
        lrck_next   = b_next[5];
`endif
    end

    // LRCK and DATA only move on the edge that drives BCK low, so they are stable while BCK is high.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div       <= '0;
            b         <= '0;
            I2S_BCK   <= 1'b0;
            I2S_LRCK  <= 1'b0;
            I2S_DATA  <= 1'b0;
            FRAME_STB <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            sh_l      <= '0;
            sh_r      <= '0;
        end else begin
            div       <= div_wrap ? '0 : div + DIV_W'(1);
            FRAME_STB <= frame_load;
            if (div_wrap) begin
                I2S_BCK <= ~I2S_BCK;
            end
            if (SAMPLE_STB) begin
                hold_l <= AUDIO_L;
                hold_r <= AUDIO_R;
            end
            if (bck_fall) begin
                b        <= b_next;
                I2S_LRCK <= lrck_next;
                I2S_DATA <= data_next;
            end
            if (frame_load) begin
                sh_l <= in_l;
                sh_r <= in_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: frame vectors, corner sequences and a per-cycle reference model.
// Honours I2S_LEFT_JUSTIFIED_EN the same way as the design.
module tb_i2s_audio_tx;

    localparam int BH = 2;
    localparam int SB = 16;
    localparam int FR = 128 * BH;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b1;
    logic          SAMPLE_STB = 1'b0;
    logic [SB-1:0] AUDIO_L = '0;
    logic [SB-1:0] AUDIO_R = '0;
    logic          FRAME_STB;
    logic          I2S_BCK;
    logic          I2S_LRCK;
    logic          I2S_DATA;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    int            t = 0;
    logic [SB-1:0] latest_l = '0, latest_r = '0;
    logic [SB-1:0] cur_l = '0, cur_r = '0;

    typedef struct {
        logic [SB-1:0] l;
        logic [SB-1:0] r;
        logic [63:0]   exp_bits;
    } vec_t;

    vec_t vecs[4];

    i2s_audio_tx #(.BCK_HALF(BH), .SAMPLE_BITS(SB)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .AUDIO_L(AUDIO_L),
        .AUDIO_R(AUDIO_R),
        .SAMPLE_STB(SAMPLE_STB),
        .FRAME_STB(FRAME_STB),
        .I2S_BCK(I2S_BCK),
        .I2S_LRCK(I2S_LRCK),
        .I2S_DATA(I2S_DATA)
    );

    always #5 CLK = ~CLK;

    // Reference: t counts clock edges since reset; every FR edges the latest captured pair becomes the frame's word.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            t        <= 0;
            latest_l <= '0;
            latest_r <= '0;
            cur_l    <= '0;
            cur_r    <= '0;
        end else begin
            t <= t + 1;
            if (SAMPLE_STB) begin
                latest_l <= AUDIO_L;
                latest_r <= AUDIO_R;
            end
            if ((t + 1) % FR == 0) begin
                cur_l <= SAMPLE_STB ? AUDIO_L : latest_l;
                cur_r <= SAMPLE_STB ? AUDIO_R : latest_r;
            end
        end
    end

    function automatic logic expBck(int tt);
        return ((tt / BH) % 2) == 1;
    endfunction

    function automatic int slotOf(int tt);
        return (tt / (2 * BH)) % 64;
    endfunction

    function automatic logic expLrck(int tt);
`ifdef I2S_LEFT_JUSTIFIED_EN
        if (tt < 2 * BH) return 1'b0;
        return slotOf(tt) < 32;
`else
        return slotOf(tt) >= 32;
`endif
    endfunction

    function automatic logic expData(int tt, logic [SB-1:0] wl, logic [SB-1:0] wr);
        int bs;
        int p;
        logic [SB-1:0] w;
        bs = slotOf(tt);
        p  = bs % 32;
        w  = (bs >= 32) ? wr : wl;
`ifdef I2S_LEFT_JUSTIFIED_EN
        if (p < SB) return w[SB-1-p];
`else
        if (p >= 1 && p <= SB) return w[SB-p];
`endif
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            checkOutput("model_bck", 64'(I2S_BCK), 64'(expBck(t)));
            checkOutput("model_lrck", 64'(I2S_LRCK), 64'(expLrck(t)));
            checkOutput("model_data", 64'(I2S_DATA), 64'(expData(t, cur_l, cur_r)));
            checkOutput("model_fstb", 64'(FRAME_STB), 64'((t > 0) && (t % FR == 0)));
        end
    end

    task automatic applyStimulus(input logic [SB-1:0] l, input logic [SB-1:0] r);
        AUDIO_L    = l;
        AUDIO_R    = r;
        SAMPLE_STB = 1'b1;
        @(negedge CLK);
        SAMPLE_STB = 1'b0;
    endtask

    task automatic waitFrameStb();
        int n;
        n = 0;
        while (FRAME_STB !== 1'b1 && n < FR + 8) begin
            @(negedge CLK);
            n++;
        end
        if (n >= FR + 8) checkOutput("fstb_timeout", 64'd0, 64'd1);
    endtask

    // Called on the FRAME_STB cycle; samples each slot in the middle of its BCK-high phase.
    task automatic captureFrame(output logic [63:0] bits, output logic [63:0] lr);
        bits = '0;
        lr   = '0;
        for (int s = 0; s < 64; s++) begin
            repeat (BH) @(negedge CLK);
            bits[63-s] = I2S_DATA;
            lr[63-s]   = I2S_LRCK;
            repeat (BH) @(negedge CLK);
        end
    endtask

    initial begin
        logic [63:0] bits;
        logic [63:0] lr;
        logic [63:0] exp_lr;
        logic [31:0] exp_coinc;
        int n;

`ifdef I2S_LEFT_JUSTIFIED_EN
        exp_lr    = 64'hFFFFFFFF_00000000;
        exp_coinc = 32'h7FFF0000;
        vecs[0] = '{16'hA5C3, 16'h8001, 64'hA5C30000_80010000};
        vecs[1] = '{16'h7FFF, 16'h0000, 64'h7FFF0000_00000000};
        vecs[2] = '{16'h1234, 16'hFEDC, 64'h12340000_FEDC0000};
        vecs[3] = '{16'h8000, 16'h0000, 64'h80000000_00000000};
`else
        exp_lr    = 64'h00000000_FFFFFFFF;
        exp_coinc = 32'h3FFF8000;
        vecs[0] = '{16'hA5C3, 16'h8001, 64'h52E18000_40008000};
        vecs[1] = '{16'h7FFF, 16'h0000, 64'h3FFF8000_00000000};
        vecs[2] = '{16'h1234, 16'hFEDC, 64'h091A0000_7F6E0000};
        vecs[3] = '{16'h8000, 16'h0000, 64'h40000000_00000000};
`endif

        #1 RESET_N = 1'b0;
        chk_en = 1'b1;

        $display("[TB] reset hold with strobes");
        for (int i = 0; i < 6; i++) begin
            AUDIO_L    = 16'hFFFF;
            AUDIO_R    = 16'hFFFF;
            SAMPLE_STB = (i % 2 == 0);
            @(negedge CLK);
            checkOutput("rst_outs", 64'({FRAME_STB, I2S_BCK, I2S_LRCK, I2S_DATA}), 64'd0);
        end
        SAMPLE_STB = 1'b0;
        RESET_N    = 1'b1;

        waitFrameStb();
        @(negedge CLK);
        waitFrameStb();
        captureFrame(bits, lr);
        checkOutput("rst_hold_zero", bits, 64'd0);

        $display("[TB] frame vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].l, vecs[i].r);
            waitFrameStb();
            captureFrame(bits, lr);
            checkOutput("vec_bits", bits, vecs[i].exp_bits);
            checkOutput("vec_lrck", lr, exp_lr);
        end

        $display("[TB] strobe coinciding with load");
        applyStimulus(16'h1111, 16'h2222);
        n = 0;
        while ((t + 1) % FR != 0 && n < FR + 8) begin
            @(negedge CLK);
            n++;
        end
        if (n >= FR + 8) checkOutput("coinc_timeout", 64'd0, 64'd1);
        AUDIO_L    = 16'h7FFF;
        AUDIO_R    = 16'h0000;
        SAMPLE_STB = 1'b1;
        @(negedge CLK);
        SAMPLE_STB = 1'b0;
        checkOutput("coinc_fstb", 64'(FRAME_STB), 64'd1);
        captureFrame(bits, lr);
        checkOutput("coinc_left", 64'(bits[63:32]), 64'(exp_coinc));

        $display("[TB] replay without strobes");
        applyStimulus(vecs[2].l, vecs[2].r);
        waitFrameStb();
        for (int k = 0; k < 3; k++) begin
            captureFrame(bits, lr);
            checkOutput("replay_bits", bits, vecs[2].exp_bits);
            checkOutput("replay_fstb", 64'(FRAME_STB), 64'd1);
        end

        $display("[TB] random strobes");
        for (int i = 0; i < 3 * FR; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 39) == 0) begin
                AUDIO_L    = SB'($urandom);
                AUDIO_R    = SB'($urandom);
                SAMPLE_STB = 1'b1;
            end else begin
                SAMPLE_STB = 1'b0;
            end
        end
        @(negedge CLK);
        SAMPLE_STB = 1'b0;

        $display("[TB] reset mid-frame");
        n = 0;
        while (slotOf(t) != 40 && n < FR + 8) begin
            @(negedge CLK);
            n++;
        end
        if (n >= FR + 8) checkOutput("b40_timeout", 64'd0, 64'd1);
        #1 RESET_N = 1'b0;
        #1 checkOutput("midrst_outs", 64'({FRAME_STB, I2S_BCK, I2S_LRCK, I2S_DATA}), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        n = 0;
        while (I2S_BCK !== 1'b1 && n < 4 * BH) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("first_rise", 64'(n), 64'(BH));
        waitFrameStb();
        captureFrame(bits, lr);
        checkOutput("post_rst_zero", bits, 64'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
# i2s_audio_tx

Serialises the core's 16-bit stereo PCM samples into an I2S bitstream for the board's `I2S_BCK` / `I2S_LRCK` / `I2S_DATA` pins. The same pins are mirrored to the HDMI audio inputs. It sits between the core's audio mixer and the top-level pins, and runs on the core system clock. A fixed 64-BCK frame (32 slots per channel) carries zero-padded samples, and a frame strobe tells the mixer when a sample pair has been consumed.

## Interface
Parameters:
- `BCK_HALF`, default 8: clk cycles per BCK half-period; legal range ≥2. BCK = CLK/(2·BCK_HALF).
- `SAMPLE_BITS`, default 16: sample width; legal range 1..31.

Ports:
- `CLK` in 1: system clock; all logic is in this single domain.
- `RESET_N` in 1: asynchronous, active-low reset.
- `AUDIO_L` in SAMPLE_BITS: left sample, two's complement.
- `AUDIO_R` in SAMPLE_BITS: right sample, two's complement.
- `SAMPLE_STB` in 1: one-cycle strobe; captures `AUDIO_L`/`AUDIO_R` into the holding registers.
- `FRAME_STB` out 1: one-cycle pulse when the holding pair is loaded into the shifter.
- `I2S_BCK` out 1: bit clock.
- `I2S_LRCK` out 1: word select.
- `I2S_DATA` out 1: serial data, MSB first.

## Operation
- Divider `div` counts 0..BCK_HALF-1. On wrap, `I2S_BCK` toggles.
- Slot counter `b` counts 0..63. It advances only on a BCK falling transition (wrap while `I2S_BCK`=1) and wraps from 63 to 0.
- `I2S_LRCK` = (b ≥ 32): 0 = left, 1 = right.
- Within a channel, p = b mod 32:
  - p=0: DATA=0 (I2S one-bit delay).
  - p=1..SAMPLE_BITS: bit SAMPLE_BITS-p of the channel word.
  - Remaining slots: 0.
- Holding registers `hold_l`/`hold_r` load on `SAMPLE_STB`.
- On the b 63→0 transition:
  - Shifter words `sh_l`/`sh_r` load from the holding registers.
  - `FRAME_STB`=1 for that one cycle.
- If `SAMPLE_STB` coincides with the load, the incoming `AUDIO_L`/`AUDIO_R` bypass into the shifter and into hold.
- No new strobe in a frame: the previous pair is replayed. There is no underrun flag.
- Multiple strobes in a frame: the last one wins.
- `SAMPLE_STB` is accepted in every cycle, including while `RESET_N` deasserts. Strobes while reset is asserted are ignored.

## Timing
- Reset values:
  - `I2S_BCK`=0, `I2S_LRCK`=0, `I2S_DATA`=0, `FRAME_STB`=0.
  - div=0, b=0.
  - hold and shifter words = 0.
- After reset release, the first BCK rise occurs BCK_HALF cycles later and the first fall 2·BCK_HALF cycles later.
- `I2S_LRCK` and `I2S_DATA` are registered and change in the same clk edge that drives `I2S_BCK` low. They are stable across the entire BCK-high phase, so the receiver samples on the rising edge.
- Frame = 128·BCK_HALF clk cycles. `FRAME_STB` period = 128·BCK_HALF.
- Latency:
  - `SAMPLE_STB` to first MSB on the pin: ≤ one frame + 2·BCK_HALF cycles.
  - From the load edge: the MSB appears at the BCK fall after b=0, i.e. the p=1 slot.
- Asynchronous reset mid-frame immediately forces all outputs low. The frame restarts at b=0 with zero words.

## Configuration
- `I2S_LEFT_JUSTIFIED_EN`
  - Defined: left-justified format.
    - `I2S_LRCK` = (b < 32), so 1 = left.
    - MSB at p=0, bits at p=0..SAMPLE_BITS-1, rest zero.
    - No one-bit delay.
  - Undefined: standard I2S exactly as described in Operation.
  - Divider, strobe and handshake behaviour are identical in both modes.

## Test plan
- Reset: hold `RESET_N`=0, toggle CLK, pulse `SAMPLE_STB` → all outputs stay 0; `FRAME_STB` never pulses.
- BCK_HALF=2, SAMPLE_BITS=16, `SAMPLE_STB` with L=16'hA5C3, R=16'h8001:
  - `FRAME_STB` every 256 cycles.
  - The next frame shows a 0 at the left p=0 slot, then 1010010111000011, then fifteen 0s.
  - The right half shows 0, then 1000000000000001, then zeros.
- `SAMPLE_STB` in the same cycle as the 63→0 load with L=16'h7FFF → that frame carries 16'h7FFF, not the prior hold value.
- No strobe for 3 frames after L=16'h1234 → 16'h1234 is replayed in each frame; `FRAME_STB` still pulses each frame.
- Pull `RESET_N` low at b=40 → outputs go 0 within the same cycle. After release, the first BCK rise comes after exactly BCK_HALF cycles.
- With `I2S_LEFT_JUSTIFIED_EN`, L=16'h8000 → `I2S_DATA`=1 at the first slot with `I2S_LRCK`=1, then 0s.
